ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit at the execute end of the ID/EX pipeline register. It consumes the decoded M-extension operation and operand values that ID/EX presents, and asserts a stall so the front end and ID/EX hold for the duration. It returns a single 32-bit result to the EX/MEM path with a one-cycle done strobe. It implements all eight RV32M operations with radix-2 shift-add multiply and restoring divide.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/ex_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU core types: RV32M funct3 encoding, mul/div FSM states and iteration count.
package cpu_pkg;

    localparam int unsigned MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected when the result is loaded.
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = MULDIV_ITER
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(ITER);

    // Two's-complement negate when neg is set; 0x80000000 maps onto itself.
    function automatic logic [PW-1:0] sign_fix(input logic [PW-1:0] x, input logic neg);
        return neg ? (~x + PW'(1)) : x;
    endfunction

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]  opb_q, opb_d;
    muldiv_op_e       op_q, op_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [2:0]       op_bits;
    logic             a_signed, b_signed;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, div_ovf;

    logic [PW-1:0]    prod_step, div_step, acc_step, fixed;
    logic [XLEN:0]    rem_shift;
    logic             sub_ok;
    logic [XLEN-1:0]  rem_next, div_word, final_res;

    assign op_bits = 3'(op_q);

    // Operand decode for the instruction presented by ID/EX.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'(OP_MUL), 3'(OP_MULH), 3'(OP_DIV), 3'(OP_REM): begin
                a_signed = rs1_val[XLEN-1];
                b_signed = rs2_val[XLEN-1];
            end
            3'(OP_MULHSU): a_signed = rs1_val[XLEN-1];
            default: ;
        endcase
        a_mag    = a_signed ? (~rs1_val + XLEN'(1)) : rs1_val;
        b_mag    = b_signed ? (~rs2_val + XLEN'(1)) : rs2_val;
        div_zero = funct3[2] & (rs2_val == '0);
        div_ovf  = funct3[2] & ~funct3[0]
                 & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
    end

    // One iteration of the datapath plus the sign-corrected result it would produce.
    always_comb begin
        prod_step = acc_q + (opb_q[0] ? mcand_q : '0);
        rem_shift = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
        sub_ok    = rem_shift >= {1'b0, opb_q};
        rem_next  = sub_ok ? XLEN'(rem_shift - {1'b0, opb_q}) : XLEN'(rem_shift);
        div_step  = {rem_next, acc_q[XLEN-2:0], sub_ok};
        acc_step  = op_bits[2] ? div_step : prod_step;
        div_word  = op_bits[1] ? acc_step[PW-1:XLEN] : acc_step[XLEN-1:0];
        fixed     = sign_fix(op_bits[2] ? {{XLEN{1'b0}}, div_word} : acc_step, neg_q);
        final_res = (op_q == OP_MUL || op_bits[2]) ? fixed[XLEN-1:0] : fixed[PW-1:XLEN];
    end

    // Next-state and register update logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = muldiv_op_e'(funct3);
                    if (div_zero) begin
                        result_d = funct3[1] ? rs1_val : '1;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        count_d = '0;
                        opb_d   = b_mag;
                        state_d = CALC;
                        if (funct3[2]) begin
                            acc_d   = {{XLEN{1'b0}}, a_mag};
                            mcand_d = '0;
                            neg_d   = funct3[1] ? a_signed : (a_signed ^ b_signed);
                        end else begin
                            acc_d   = '0;
                            mcand_d = {{XLEN{1'b0}}, a_mag};
                            neg_d   = a_signed ^ b_signed;
                        end
                    end
                end
            end
            CALC: begin
                acc_d   = acc_step;
                count_d = count_q + CNT_W'(1);
                if (!op_bits[2]) begin
                    mcand_d = mcand_q << 1;
                    opb_d   = opb_q >> 1;
                end
                if (count_q == CNT_W'(ITER - 1)) begin
                    result_d = final_res;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A killed instruction must leave no trace on the result path.
        if (flush) begin
            state_d  = IDLE;
            count_d  = '0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign stall  = (state_q == CALC) | ((state_q == IDLE) & start & ~flush);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, abort cases and
// randomized operations against an arithmetic reference model.
module tb_ex_muldiv_unit;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_result = '0;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int              sa, sb;
        longint          p;
        longint unsigned pu;
        logic [63:0]     v;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb); v = p; return v[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); v = p; return v[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'h0, b}); v = p; return v[63:32]; end
            3'd3: begin pu = {32'h0, a} * {32'h0, b}; v = pu; return v[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Present one instruction (called just after a posedge, i.e. cycle 0) and hold
    // start like a stalled ID/EX would; returns just after the edge ending DONE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat, got_lat;
        exp     = ref_result(op, a, b);
        lat     = is_special(op, a, b) ? 1 : 33;
        got_lat = -1;
        start   = 1'b1;
        funct3  = op;
        rs1_val = a;
        rs2_val = b;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clock);
            if (done) begin
                got_lat = cyc;
                check_eq($sformatf("result op%0d %h,%h", op, a, b), 64'(result), 64'(exp));
                check_eq("stall_in_done", 64'(stall), 64'h0);
                @(posedge clock);
                #1;
                break;
            end
            check_eq($sformatf("stall_cyc%0d", cyc), 64'(stall), 64'h1);
            @(posedge clock);
            #1;
        end
        check_eq($sformatf("latency op%0d", op), 64'(got_lat), 64'(lat));
        last_result = exp;
    endtask

    task automatic idle_check(input int n);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_eq("idle_done", 64'(done), 64'h0);
            check_eq("idle_stall", 64'(stall), 64'h0);
            check_eq("idle_result", 64'(result), 64'(last_result));
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = '0;
        rs1_val = '0;
        rs2_val = '0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check_eq("reset_done", 64'(done), 64'h0);
        check_eq("reset_stall", 64'(stall), 64'h0);
        check_eq("reset_result", 64'(result), 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_check(2);

        // Directed arithmetic cases.
        run_op(OP_MUL,    32'd7,         32'hFFFF_FFFD);
        idle_check(1);
        run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000);
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2);
        run_op(OP_REM,    32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU,   32'd100,       32'd7);
        run_op(OP_REMU,   32'd100,       32'd7);
        idle_check(1);

        // Special cases bypassing the iteration.
        run_op(OP_DIVU,   32'd5,         32'd0);
        run_op(OP_REM,    32'd5,         32'd0);
        run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF);
        idle_check(1);

        // Back-to-back multiplies with no bubble beyond DONE.
        run_op(OP_MUL, 32'd3, 32'd4);
        run_op(OP_MUL, 32'd5, 32'd6);
        idle_check(1);

        // Flush in cycle 10 of a divide: back to IDLE, nothing reported.
        start   = 1'b1;
        funct3  = OP_DIV;
        rs1_val = 32'd1000;
        rs2_val = 32'd3;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        flush = 1'b1;
        @(negedge clock);
        check_eq("flush_cyc10_stall", 64'(stall), 64'h1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check_eq("flush_cyc11_stall", 64'(stall), 64'h0);
        check_eq("flush_cyc11_done", 64'(done), 64'h0);
        check_eq("flush_cyc11_result", 64'(result), 64'(last_result));
        @(posedge clock);
        #1;
        flush = 1'b0;
        idle_check(40);

        // Reset in cycle 20 of a multiply clears all outputs.
        run_op(OP_REMU, 32'd77, 32'd10);
        start   = 1'b1;
        funct3  = OP_MULHU;
        rs1_val = 32'hDEAD_BEEF;
        rs2_val = 32'h1234_5678;
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        last_result = '0;
        @(negedge clock);
        check_eq("rst_mid_done", 64'(done), 64'h0);
        check_eq("rst_mid_stall", 64'(stall), 64'h0);
        check_eq("rst_mid_result", 64'(result), 64'h0);
        @(posedge clock);
        #1;
        idle_check(40);

        // Randomized operations, sometimes back-to-back.
        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            if ($urandom_range(0, 2) == 0) idle_check(int'($urandom_range(1, 2)));
        end
        idle_check(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
